// File: rtl/hp_responder.sv
// hp_responder: AXI3 slave responder backed by a word-addressed register array.
// Serves one read or write burst at a time; IDLE arbitration alternates between
// the write and read address channels when both are presented together.
module hp_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clock,
    input  logic        reset,
    // write address
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [5:0]  awid,
    // write data
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic [5:0]  wid,
    // write response
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [5:0]  bid,
    // read address
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [5:0]  arid,
    // read data
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [5:0]  rid,
    output logic        rlast
);

    localparam int unsigned IW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        prefer_w_q, prefer_w_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [5:0]  id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    // Beat decode for the current burst address
    logic [31:0]   word_off;
    logic          in_range;
    logic          fmt_ok;
    logic          rd_ok;
    logic          wr_ok;
    logic          last_beat;
    logic [IW-1:0] idx;
    logic [31:0]   next_addr;

    assign word_off  = (addr_q - BASE_ADDR) >> 2;
    assign in_range  = (addr_q >= BASE_ADDR) && (word_off < DEPTH_W);
    assign idx       = word_off[IW-1:0];
    assign fmt_ok    = (size_q == 3'b010) && !burst_q[1];
    assign rd_ok     = fmt_ok && in_range;
    assign wr_ok     = rd_ok && (wid == id_q);
    assign last_beat = (cnt_q == len_q);
    assign next_addr = (burst_q == 2'b01) ? addr_q + 32'd4 : addr_q;

    // Address-channel arbitration: only in IDLE, ties broken by prefer_w
    assign awready = (state_q == S_IDLE) && awvalid && (!arvalid || prefer_w_q);
    assign arready = (state_q == S_IDLE) && arvalid && (!awvalid || !prefer_w_q);

    assign wready = (state_q == S_WDATA);
    assign bvalid = (state_q == S_WRESP);
    assign bresp  = (bvalid && err_q) ? 2'b10 : 2'b00;
    assign bid    = bvalid ? id_q : '0;

    assign rvalid = (state_q == S_RDATA);
    assign rlast  = rvalid && last_beat;
    assign rdata  = (rvalid && rd_ok) ? mem_q[idx] : '0;
    assign rresp  = (rvalid && !rd_ok) ? 2'b10 : 2'b00;
    assign rid    = rvalid ? id_q : '0;

    // Next-state logic for the transaction FSM and burst tracking
    always_comb begin
        state_d    = state_q;
        prefer_w_d = prefer_w_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (awready) begin
                    addr_d     = awaddr;
                    len_d      = awlen;
                    size_d     = awsize;
                    burst_d    = awburst;
                    id_d       = awid;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    prefer_w_d = !prefer_w_q;
                    state_d    = S_WDATA;
                end else if (arready) begin
                    addr_d     = araddr;
                    len_d      = arlen;
                    size_d     = arsize;
                    burst_d    = arburst;
                    id_d       = arid;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    prefer_w_d = !prefer_w_q;
                    state_d    = S_RDATA;
                end
            end
            S_WDATA: begin
                if (wvalid) begin
                    if (!wr_ok || (wlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 4'd1;
                    if (last_beat) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d = next_addr;
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and burst registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            prefer_w_q <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefer_w_q <= prefer_w_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Backing array: byte-strobed writes on good W beats, contents survive reset
    always_ff @(posedge clock) begin
        if ((state_q == S_WDATA) && wvalid && wr_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_hp_responder.sv
// Directed bench for hp_responder with a transaction-level memory model.
module tb_hp_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic [5:0]  awid = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic [5:0]  wid = '0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic [5:0]  bid;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic [5:0]  arid = '0;
    logic        rvalid, rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [5:0]  rid;
    logic        rlast;

    hp_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast)
    );

    always #5 clock = ~clock;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    // ---------------- model ----------------
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [5:0] id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic [5:0] id; } bbeat_t;

    logic [31:0] mmem [int];
    bit          pw = 1'b1;
    rbeat_t      exp_r[$];
    bbeat_t      exp_b[$];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] cap_d [16];
    logic [1:0]  cap_r [16];
    logic        cap_l [16];
    logic [1:0]  cap_bresp;
    logic [5:0]  cap_bid;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (reset) begin
            if (rvalid) begin
                if (exp_r.size() == 0) chk1("r_unexpected", rvalid, 1'b0);
                else begin
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rresp", {30'b0, rresp}, {30'b0, exp_r[0].resp});
                    chk1("rlast", rlast, exp_r[0].last);
                    chk("rid", {26'b0, rid}, {26'b0, exp_r[0].id});
                    if (rready) void'(exp_r.pop_front());
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) chk1("b_unexpected", bvalid, 1'b0);
                else begin
                    chk("bresp", {30'b0, bresp}, {30'b0, exp_b[0].resp});
                    chk("bid", {26'b0, bid}, {26'b0, exp_b[0].id});
                    if (bready) void'(exp_b.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic set_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [5:0] i);
        awaddr = a; awlen = l; awsize = s; awburst = b; awid = i; awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [5:0] i);
        araddr = a; arlen = l; arsize = s; arburst = b; arid = i; arvalid = 1'b1;
    endtask

    task automatic wait_addr(output bit got_w);
        bit both;
        bit done;
        done  = 1'b0;
        got_w = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            both = awvalid && arvalid;
            @(negedge clock);
            if (awready || arready) begin
                if (both) begin
                    chk1("pick_aw", awready, pw);
                    chk1("pick_ar", arready, !pw);
                end else begin
                    chk1("single_ready", awready && arready, 1'b0);
                end
                got_w = awready;
                done  = 1'b1;
            end
        end
        if (!done) chk1("addr_timeout", awready || arready, 1'b1);
        @(posedge clock); #1;
        if (done) begin
            pw = !pw;
            if (got_w) awvalid = 1'b0;
            else arvalid = 1'b0;
        end
    endtask

    task automatic run_w(input logic [5:0] wid_v, input int lastpos, input bit hold_b);
        logic [31:0] a, w;
        int          n;
        bit          ok, err;
        bbeat_t      e;
        a   = awaddr;
        n   = int'(awlen);
        err = 1'b0;
        for (int b = 0; b <= n; b++) begin
            ok = (awsize == 3'b010) && (awburst < 2'b10) && (wid_v == awid) && in_rng(a);
            if (ok) begin
                w = mmem.exists(widx(a)) ? mmem[widx(a)] : 32'h0;
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) w[8*k +: 8] = wd[b][8*k +: 8];
                mmem[widx(a)] = w;
            end
            if (!ok || ((b == lastpos) != (b == n))) err = 1'b1;
            if (awburst == 2'b01) a = a + 32'd4;
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = awid;
        exp_b.push_back(e);
        bready = !hold_b;
        for (int b = 0; b <= n; b++) begin
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == lastpos); wid = wid_v;
            @(negedge clock);
            chk1("wready", wready, 1'b1);
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clock);
        chk1("b_timing", bvalid, 1'b1);
        cap_bresp = bresp;
        cap_bid   = bid;
        if (hold_b) begin
            @(posedge clock); #1;
            bready = 1'b1;
            @(negedge clock);
            chk1("b_hold", bvalid, 1'b1);
        end
        @(posedge clock); #1;
    endtask

    task automatic run_r(input int abort_at);
        logic [31:0] a;
        int          n;
        bit          ok;
        rbeat_t      e;
        a = araddr;
        n = int'(arlen);
        for (int b = 0; b <= n; b++) begin
            ok = (arsize == 3'b010) && (arburst < 2'b10) && in_rng(a);
            e.data = ok ? mmem[widx(a)] : 32'h0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.last = (b == n);
            e.id   = arid;
            exp_r.push_back(e);
            if (arburst == 2'b01) a = a + 32'd4;
        end
        for (int b = 0; b <= n; b++) begin
            if (b == abort_at) begin
                #2 reset = 1'b0;
                #1 chk1("rst_drop_rvalid", rvalid, 1'b0);
                exp_r.delete();
                return;
            end
            @(negedge clock);
            chk1("r_valid", rvalid, 1'b1);
            cap_d[b] = rdata; cap_r[b] = rresp; cap_l[b] = rlast;
            @(posedge clock); #1;
        end
    endtask

    task automatic idle_check();
        @(negedge clock);
        chk1("idle_rvalid", rvalid, 1'b0);
        chk1("idle_bvalid", bvalid, 1'b0);
        chk1("idle_wready", wready, 1'b0);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chk("rst_resp", {28'b0, bresp, rresp}, 32'h0);
        chk("rst_ids", {20'b0, bid, rid}, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        pw = 1'b1;
        exp_r.delete();
        exp_b.delete();
    endtask

    task automatic fill_full();
        for (int i = 0; i < 16; i++) ws[i] = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit g;
        fill_full();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Simultaneous AW/AR from reset, twice: write wins, then read follows
        for (int r = 0; r < 2; r++) begin
            wd[0] = 32'hA5A5_0000 + 32'(r);
            set_aw(BASE + 32'h20 + 32'(4*r), 4'd0, 3'b010, 2'b01, 6'd1);
            set_ar(BASE + 32'h20 + 32'(4*r), 4'd0, 3'b010, 2'b01, 6'd2);
            wait_addr(g);
            chk1("both_write_first", g, 1'b1);
            run_w(6'd1, 0, 1'b0);
            wait_addr(g);
            chk1("both_read_second", g, 1'b0);
            run_r(-1);
            chk("both_rdata", cap_d[0], 32'hA5A5_0000 + 32'(r));
        end
        idle_check();

        // After a lone write, the next tie goes to the read
        wd[0] = 32'h1234_5678;
        set_aw(BASE + 32'h30, 4'd0, 3'b010, 2'b01, 6'd3);
        wait_addr(g);
        run_w(6'd3, 0, 1'b0);
        wd[0] = 32'h8765_4321;
        set_aw(BASE + 32'h34, 4'd0, 3'b010, 2'b01, 6'd4);
        set_ar(BASE + 32'h30, 4'd0, 3'b010, 2'b01, 6'd4);
        wait_addr(g);
        chk1("tie_read_first", g, 1'b0);
        run_r(-1);
        chk("tie_rdata", cap_d[0], 32'h1234_5678);
        wait_addr(g);
        chk1("tie_write_next", g, 1'b1);
        run_w(6'd4, 0, 1'b0);
        idle_check();

        // Single write then readback
        wd[0] = 32'hDEADBEEF;
        set_aw(BASE + 32'h8, 4'd0, 3'b010, 2'b01, 6'd5);
        wait_addr(g);
        run_w(6'd5, 0, 1'b0);
        chk("t1_bresp", {30'b0, cap_bresp}, 32'h0);
        chk("t1_bid", {26'b0, cap_bid}, 32'd5);
        set_ar(BASE + 32'h8, 4'd0, 3'b010, 2'b01, 6'd5);
        wait_addr(g);
        run_r(-1);
        chk("t1_rdata", cap_d[0], 32'hDEADBEEF);
        chk("t1_rresp", {30'b0, cap_r[0]}, 32'h0);
        chk1("t1_rlast", cap_l[0], 1'b1);

        // INCR len 3 with partial strobe on beat 2, held B
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h5555_1234; wd[3] = 32'h4444_4444;
        ws[2] = 4'b0011;
        set_aw(BASE, 4'd3, 3'b010, 2'b01, 6'd7);
        wait_addr(g);
        run_w(6'd7, 3, 1'b1);
        fill_full();
        chk("t2_bresp", {30'b0, cap_bresp}, 32'h0);
        set_ar(BASE, 4'd3, 3'b010, 2'b01, 6'd8);
        wait_addr(g);
        run_r(-1);
        chk("t2_word2", cap_d[2], 32'hDEAD_1234);
        chk("t2_rlast", {28'b0, cap_l[3], cap_l[2], cap_l[1], cap_l[0]}, 32'b1000);
        idle_check();

        // FIXED read repeats the same word; reserved burst type errors every beat
        set_ar(BASE + 32'h8, 4'd2, 3'b010, 2'b00, 6'd9);
        wait_addr(g);
        run_r(-1);
        chk("fixed_beat2", cap_d[2], 32'hDEAD_1234);
        set_ar(BASE + 32'h8, 4'd1, 3'b010, 2'b10, 6'd9);
        wait_addr(g);
        run_r(-1);
        chk("rsvd_resp", {30'b0, cap_r[1]}, 32'd2);

        // Read running off the top of the array
        wd[0] = 32'hCAFE_F00D;
        set_aw(BASE + 32'(DEPTH*4) - 32'd4, 4'd0, 3'b010, 2'b01, 6'd6);
        wait_addr(g);
        run_w(6'd6, 0, 1'b0);
        set_ar(BASE + 32'(DEPTH*4) - 32'd4, 4'd1, 3'b010, 2'b01, 6'd6);
        wait_addr(g);
        run_r(-1);
        chk("top_d0", cap_d[0], 32'hCAFE_F00D);
        chk("top_r0", {30'b0, cap_r[0]}, 32'd0);
        chk("top_d1", cap_d[1], 32'h0);
        chk("top_r1", {30'b0, cap_r[1]}, 32'd2);

        // Bad size / wrong wid / early wlast
        wd[0] = 32'hBADB_AD00;
        set_aw(BASE, 4'd0, 3'b001, 2'b01, 6'd11);
        wait_addr(g);
        run_w(6'd11, 0, 1'b0);
        chk("size_bresp", {30'b0, cap_bresp}, 32'd2);
        set_aw(BASE + 32'h4, 4'd0, 3'b010, 2'b01, 6'd9);
        wait_addr(g);
        run_w(6'd10, 0, 1'b0);
        chk("wid_bresp", {30'b0, cap_bresp}, 32'd2);
        for (int i = 0; i < 3; i++) ws[i] = 4'b0000;
        set_aw(BASE, 4'd2, 3'b010, 2'b01, 6'd3);
        wait_addr(g);
        run_w(6'd3, 0, 1'b0);
        fill_full();
        chk("wlast_bresp", {30'b0, cap_bresp}, 32'd2);
        set_ar(BASE, 4'd1, 3'b010, 2'b01, 6'd1);
        wait_addr(g);
        run_r(-1);
        chk("unchanged_w0", cap_d[0], 32'h1111_1111);
        chk("unchanged_w1", cap_d[1], 32'h2222_2222);

        // Reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) wd[i] = 32'h0101_0101 * 32'(i + 1);
        set_aw(BASE + 32'h40, 4'd7, 3'b010, 2'b01, 6'd12);
        wait_addr(g);
        run_w(6'd12, 7, 1'b0);
        set_ar(BASE + 32'h40, 4'd7, 3'b010, 2'b01, 6'd13);
        wait_addr(g);
        run_r(2);
        @(negedge clock);
        chk1("rst_hold_rvalid", rvalid, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        pw = 1'b1;
        exp_b.delete();
        set_ar(BASE + 32'h44, 4'd0, 3'b010, 2'b01, 6'd14);
        wait_addr(g);
        chk1("post_rst_ar", g, 1'b0);
        run_r(-1);
        chk("post_rst_rdata", cap_d[0], 32'h0202_0202);
        idle_check();

        chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
